// File: rtl/enc_rr_queue_if.sv
// Handshake bundle for enc_rr_queue.
//   master : request/consumer side (drives en, a, ready; observes y, valid, pend, drop)
//   slave  : encoder side (observes en, a, ready; drives y, valid, pend, drop)
interface enc_rr_queue_if #(
  parameter int N = 8
) ();
  localparam int W = $clog2(N);

  logic         en;
  logic [N-1:0] a;
  logic [W-1:0] y;
  logic         valid;
  logic         ready;
  logic [N-1:0] pend;
  logic         drop;

  modport master (output en, a, ready, input y, valid, pend, drop);
  modport slave  (input en, a, ready, output y, valid, pend, drop);
endinterface

// File: rtl/enc_rr_queue.sv
// Registered request encoder with a pending register and valid/ready output.
// Requests on bus.a (gated by bus.en) are OR-ed into a pending register; one
// pending bit per cycle is encoded into bus.y, either lowest-index-first
// (MODE=0) or round-robin from a rotating pointer (MODE=1).
//   clk   : rising-edge clock
//   rst   : synchronous reset, active-high
//   bus   : slave modport -- en, a, ready in; y, valid, pend, drop out
module enc_rr_queue #(
  parameter int N    = 8,
  parameter int MODE = 0
) (
  input  logic         clk,
  input  logic         rst,
  enc_rr_queue_if.slave bus
);
  localparam int W = $clog2(N);

  logic [N-1:0] pend;
  logic [W-1:0] y;
  logic         valid;
  logic         drop;
  logic [W-1:0] ptr;

  logic [W-1:0] sel;
  logic         load;
  logic [N-1:0] clr;
  logic [W-1:0] ptr_nxt;
  logic [N-1:0] cap;

  // Scan start is 0 for fixed priority, ptr for round-robin; the scan index
  // wraps explicitly so non-power-of-two N works.
  always_comb begin
    int idx;
    logic found;
    sel   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      if (MODE == 0) begin
        idx = k;
      end else begin
        idx = int'(ptr) + k;
        if (idx >= N) idx = idx - N;
      end
      if (!found && pend[idx]) begin
        sel   = W'(idx);
        found = 1'b1;
      end
    end
  end

  // Output register is free when empty or being drained this cycle.
  assign load    = (!valid || bus.ready) && (pend != '0);
  assign clr     = load ? ({{(N-1){1'b0}}, 1'b1} << sel) : '0;
  assign ptr_nxt = (sel == W'(N - 1)) ? '0 : sel + 1'b1;
  assign cap     = bus.en ? bus.a : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      pend  <= '0;
      y     <= '0;
      valid <= 1'b0;
      drop  <= 1'b0;
      ptr   <= '0;
    end else begin
      // New captures are OR-ed after the clear, so a same-cycle re-request
      // of the granted bit keeps it pending.
      pend <= (pend & ~clr) | cap;
      drop <= |(cap & pend & ~clr);
      if (load) begin
        y     <= sel;
        valid <= 1'b1;
        if (MODE != 0) ptr <= ptr_nxt;
      end else if (valid && bus.ready) begin
        valid <= 1'b0;
      end
    end
  end

  assign bus.y     = y;
  assign bus.valid = valid;
  assign bus.pend  = pend;
  assign bus.drop  = drop;
endmodule

// File: tb/tb_enc_rr_queue.sv
// Bench for enc_rr_queue: one fixed-priority and one round-robin instance
// share the same stimulus. A spec-level model predicts each grant and pushes
// it on a per-instance queue; a negedge monitor pops on every handshake.
module tb_enc_rr_queue;
  localparam int N = 8;
  localparam int W = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic         ready;
  logic [N-1:0] a;

  always #5 clk = ~clk;

  enc_rr_queue_if #(.N(N)) bus0 ();
  enc_rr_queue_if #(.N(N)) bus1 ();

  assign bus0.en = en;  assign bus0.a = a;  assign bus0.ready = ready;
  assign bus1.en = en;  assign bus1.a = a;  assign bus1.ready = ready;

  enc_rr_queue #(.N(N), .MODE(0)) u0 (.clk(clk), .rst(rst), .bus(bus0));
  enc_rr_queue #(.N(N), .MODE(1)) u1 (.clk(clk), .rst(rst), .bus(bus1));

  logic [W-1:0] dy [2];
  logic         dv [2];
  logic [N-1:0] dp [2];
  logic         dd [2];
  assign dy[0] = bus0.y;     assign dy[1] = bus1.y;
  assign dv[0] = bus0.valid; assign dv[1] = bus1.valid;
  assign dp[0] = bus0.pend;  assign dp[1] = bus1.pend;
  assign dd[0] = bus0.drop;  assign dd[1] = bus1.drop;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit [N-1:0] m_pend  [2];
  bit         m_valid [2];
  bit         m_drop  [2];
  int         m_ptr   [2];
  int         q0[$];
  int         q1[$];

  // First requesting index when scanning upward from start, wrapping.
  function automatic int pick(input bit [N-1:0] p, input int start);
    for (int k = 0; k < N; k++) begin
      if (p[(start + k) % N]) return (start + k) % N;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    for (int m = 0; m < 2; m++) begin
      if (rst) begin
        m_pend[m] = '0; m_valid[m] = 1'b0; m_drop[m] = 1'b0; m_ptr[m] = 0;
        if (m == 0) q0.delete(); else q1.delete();
      end else begin
        bit         ld;
        int         g;
        bit         nd;
        bit [N-1:0] np;
        ld = (!m_valid[m] || ready) && (m_pend[m] != '0);
        g  = ld ? pick(m_pend[m], (m == 0) ? 0 : m_ptr[m]) : -1;
        nd = 1'b0;
        np = '0;
        for (int i = 0; i < N; i++) begin
          bit keep;
          bit req;
          keep  = m_pend[m][i] && (i != g);
          req   = en && a[i];
          if (req && keep) nd = 1'b1;
          np[i] = keep || req;
        end
        if (ld) begin
          if (m == 0) q0.push_back(g); else q1.push_back(g);
          m_valid[m] = 1'b1;
          m_ptr[m]   = (g + 1) % N;
        end else if (m_valid[m] && ready) begin
          m_valid[m] = 1'b0;
        end
        m_pend[m] = np;
        m_drop[m] = nd;
      end
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      for (int m = 0; m < 2; m++) begin
        chk($sformatf("valid%0d", m), 32'(dv[m]), 32'(m_valid[m]));
        chk($sformatf("pend%0d", m),  32'(dp[m]), 32'(m_pend[m]));
        chk($sformatf("drop%0d", m),  32'(dd[m]), 32'(m_drop[m]));
        if (dv[m] === 1'b1 && ready === 1'b1) begin
          int e;
          if ((m == 0 ? q0.size() : q1.size()) == 0) begin
            chk($sformatf("unexpected_y%0d", m), 32'(dy[m]), 32'hFFFF_FFFF);
          end else begin
            e = (m == 0) ? q0.pop_front() : q1.pop_front();
            chk($sformatf("y%0d", m), 32'(dy[m]), 32'(e));
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset under full request load.
    rst = 1'b1; en = 1'b1; a = 8'hFF; ready = 1'b1;
    tick(); tick();
    for (int m = 0; m < 2; m++) begin
      chk("rst_pend", 32'(dp[m]), 32'h0);
      chk("rst_y", 32'(dy[m]), 32'h0);
      chk("rst_valid", 32'(dv[m]), 32'h0);
      chk("rst_drop", 32'(dd[m]), 32'h0);
    end
    rst = 1'b0; a = '0;
    tick();

    // Single request: visible two clocks after the pulse, for one cycle.
    a = 8'b0001_0000; tick();
    a = '0; tick();
    chk("single_valid", 32'(dv[0]), 32'h1);
    chk("single_y", 32'(dy[0]), 32'h4);
    tick();
    chk("single_done", 32'(dv[0]), 32'h0);

    // Fixed priority drain order.
    a = 8'b1010_0100; tick();
    a = '0; tick();
    chk("fp_y0", 32'(dy[0]), 32'h2);
    tick(); chk("fp_y1", 32'(dy[0]), 32'h5);
    tick(); chk("fp_y2", 32'(dy[0]), 32'h7); chk("fp_v2", 32'(dv[0]), 32'h1);
    tick(); chk("fp_end_v", 32'(dv[0]), 32'h0); chk("fp_end_p", 32'(dp[0]), 32'h0);

    // Round-robin from a fresh pointer, with a re-request of index 0.
    rst = 1'b1; tick(); rst = 1'b0;
    a = 8'b1000_0011; tick();
    a = '0; tick();
    chk("rr_y0", 32'(dy[1]), 32'h0);
    a = 8'b0000_0001; tick();
    chk("rr_y1", 32'(dy[1]), 32'h1);
    a = '0; tick();
    chk("rr_y2", 32'(dy[1]), 32'h7);
    tick();
    chk("rr_y3", 32'(dy[1]), 32'h0);
    tick();
    chk("rr_end", 32'(dv[1]), 32'h0);

    // Backpressure and coalescing on a held index.
    rst = 1'b1; tick(); rst = 1'b0;
    ready = 1'b0; a = 8'h08;
    tick(); tick(); tick();
    chk("bp_drop", 32'(dd[0]), 32'h1);
    chk("bp_valid", 32'(dv[0]), 32'h1);
    chk("bp_y", 32'(dy[0]), 32'h3);
    chk("bp_pend", 32'(dp[0]), 32'h08);
    a = '0; tick();
    chk("bp_drop_end", 32'(dd[0]), 32'h0);
    chk("bp_hold_y", 32'(dy[0]), 32'h3);
    ready = 1'b1; tick();
    chk("bp_again_v", 32'(dv[0]), 32'h1);
    chk("bp_again_y", 32'(dy[0]), 32'h3);
    tick();
    chk("bp_done", 32'(dv[0]), 32'h0);

    // Capture disabled, then reset with work in flight.
    ready = 1'b0; a = 8'h0F; tick();
    en = 1'b0; a = 8'hFF; tick(); tick();
    chk("en0_pend", 32'(dp[0]), 32'h0E);
    chk("en0_drop", 32'(dd[0]), 32'h0);
    rst = 1'b1; tick(); rst = 1'b0;
    en = 1'b1; a = '0; ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      chk("postrst_v0", 32'(dv[0]), 32'h0);
      chk("postrst_v1", 32'(dv[1]), 32'h0);
    end

    // Random traffic with occasional resets.
    for (int c = 0; c < 1500; c++) begin
      rst   = ($urandom_range(0, 99) == 0);
      en    = ($urandom_range(0, 9) < 8);
      ready = ($urandom_range(0, 9) < 6);
      a     = N'($urandom & $urandom & $urandom);
      tick();
    end

    // Drain; every predicted grant must have been delivered.
    rst = 1'b0; en = 1'b0; a = '0; ready = 1'b1;
    repeat (20) tick();
    chk("drain_q0", 32'(q0.size()), 32'h0);
    chk("drain_q1", 32'(q1.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
